// File: rtl/mult_div_issue_controller.sv
// Issue controller for the multi-cycle mul/div unit: accepts the reservation-station
// head, runs it on the datapath for a fixed latency, then broadcasts on the CDB.
// Optional: define MD_DIV_ZERO_BYPASS_EN to resolve divide-by-zero without the datapath.
module mult_div_issue_controller #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issueque_ready,
  input  logic [31:0] issueque_rs1_data,
  input  logic [31:0] issueque_rs2_data,
  input  logic [5:0]  issueque_rd_tag,
  input  logic [2:0]  issueque_opcode,
  output logic        issueblk_done,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic [5:0]  cdb_tag_out,
  output logic [31:0] cdb_data_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_BCAST = 2'd2
  } state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_tag;
  logic [31:0] r_result;
  logic        r_start;
  logic        w_accept;
  logic        w_bypass;
  logic [5:0]  w_lat;

  // Acceptance is suppressed while reset is held so the done pulse never leaks out.
  assign w_accept = (r_state == S_IDLE) && issueque_ready && !reset;
  assign w_lat    = issueque_opcode[2] ? DIV_CNT : MUL_CNT;

`ifdef MD_DIV_ZERO_BYPASS_EN
  logic [31:0] w_bypass_result;
  assign w_bypass        = issueque_opcode[2] && (issueque_rs2_data == 32'd0);
  // funct3 bit1 separates REM/REMU (return dividend) from DIV/DIVU (all ones).
  assign w_bypass_result = issueque_opcode[1] ? issueque_rs1_data : 32'hFFFF_FFFF;
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_bypass ? S_BCAST : S_EXEC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: begin
        if (r_cnt == 6'd1) begin
          w_next_state = S_BCAST;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_BCAST: begin
        if (cdb_grant) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_BCAST;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 6'd0;
      r_op     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_tag    <= 6'd0;
      r_result <= 32'd0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_accept && !w_bypass;
      if (w_accept) begin
        r_op  <= issueque_opcode;
        r_a   <= issueque_rs1_data;
        r_b   <= issueque_rs2_data;
        r_tag <= issueque_rd_tag;
        r_cnt <= w_lat;
`ifdef MD_DIV_ZERO_BYPASS_EN
        if (w_bypass) begin
          r_result <= w_bypass_result;
        end
`endif
      end else if (r_state == S_EXEC) begin
        r_cnt <= r_cnt - 6'd1;
        // Last execute cycle: the datapath result is valid now.
        if (r_cnt == 6'd1) begin
          r_result <= md_result;
        end
      end
    end
  end

  assign issueblk_done = w_accept;
  assign md_start      = r_start;
  assign md_op         = (r_state == S_EXEC)  ? r_op     : 3'd0;
  assign md_a          = (r_state == S_EXEC)  ? r_a      : 32'd0;
  assign md_b          = (r_state == S_EXEC)  ? r_b      : 32'd0;
  assign cdb_req       = (r_state == S_BCAST);
  assign cdb_tag_out   = (r_state == S_BCAST) ? r_tag    : 6'd0;
  assign cdb_data_out  = (r_state == S_BCAST) ? r_result : 32'd0;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_div_issue_controller.sv
// Self-checking bench for mult_div_issue_controller: timestamp-based transaction model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_mult_div_issue_controller;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 32;
  localparam logic [31:0] MR = 32'hCAFE_0005;
`ifdef MD_DIV_ZERO_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        issueque_ready;
  logic [31:0] issueque_rs1_data, issueque_rs2_data;
  logic [5:0]  issueque_rd_tag;
  logic [2:0]  issueque_opcode;
  logic        issueblk_done, md_start, cdb_req, cdb_grant, busy;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b, md_result, cdb_data_out;
  logic [5:0]  cdb_tag_out;

  mult_div_issue_controller #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .issueque_ready(issueque_ready), .issueque_rs1_data(issueque_rs1_data),
    .issueque_rs2_data(issueque_rs2_data), .issueque_rd_tag(issueque_rd_tag),
    .issueque_opcode(issueque_opcode), .issueblk_done(issueblk_done),
    .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_result(md_result),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag_out(cdb_tag_out),
    .cdb_data_out(cdb_data_out), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: one op in flight described by its acceptance cycle and latency.
  bit          in_rst;
  bit          m_active;
  bit          m_byp;
  int          m_acc, m_lat;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [5:0]  m_tag;

  logic        e_done, e_start, e_req, e_busy;
  logic [2:0]  e_op;
  logic [31:0] e_a, e_b, e_data;
  logic [5:0]  e_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit in_exec(input int c);
    return m_active && !m_byp && (c >= m_acc + 1) && (c <= m_acc + m_lat);
  endfunction

  function automatic bit in_bcast(input int c);
    return m_active && (m_byp ? (c >= m_acc + 1) : (c > m_acc + m_lat));
  endfunction

  task automatic model_update();
    if (in_rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (issueque_ready) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_op     = issueque_opcode;
        m_a      = issueque_rs1_data;
        m_b      = issueque_rs2_data;
        m_tag    = issueque_rd_tag;
        m_lat    = issueque_opcode[2] ? DIV_LAT : MUL_LAT;
        m_byp    = BYPASS_EN && issueque_opcode[2] && (issueque_rs2_data == 32'd0);
        m_res    = issueque_opcode[1] ? issueque_rs1_data : 32'hFFFF_FFFF;
      end
    end else if (in_exec(cyc) && cyc == m_acc + m_lat) begin
      m_res = md_result;
    end else if (in_bcast(cyc) && cdb_grant) begin
      m_active = 1'b0;
    end
  endtask

  task automatic model_expect();
    e_done = 1'b0; e_start = 1'b0; e_req = 1'b0; e_busy = 1'b0;
    e_op = 3'd0; e_a = 32'd0; e_b = 32'd0; e_data = 32'd0; e_tag = 6'd0;
    if (!in_rst) begin
      e_done  = !m_active && issueque_ready;
      e_busy  = m_active;
      e_start = in_exec(cyc) && (cyc == m_acc + 1);
      if (in_exec(cyc)) begin
        e_op = m_op; e_a = m_a; e_b = m_b;
      end
      if (in_bcast(cyc)) begin
        e_req = 1'b1; e_tag = m_tag; e_data = m_res;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issueblk_done", 32'(issueblk_done), 32'(e_done));
      chk("md_start", 32'(md_start), 32'(e_start));
      chk("md_op", 32'(md_op), 32'(e_op));
      chk("md_a", md_a, e_a);
      chk("md_b", md_b, e_b);
      chk("cdb_req", 32'(cdb_req), 32'(e_req));
      chk("cdb_tag_out", 32'(cdb_tag_out), 32'(e_tag));
      chk("cdb_data_out", cdb_data_out, e_data);
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic step(input logic rdy, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] tg, input logic gnt,
                      input logic [31:0] mr);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    reset = 1'b0; in_rst = 1'b0;
    issueque_ready = rdy; issueque_opcode = op; issueque_rs1_data = a;
    issueque_rs2_data = b; issueque_rd_tag = tg; cdb_grant = gnt; md_result = mr;
    model_expect();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input logic gnt);
    step(1'b0, 3'd0, 32'd0, 32'd0, 6'd0, gnt, MR);
  endtask

  task automatic zero_outputs(input string nm);
    chk({nm, "_done"}, 32'(issueblk_done), 32'd0);
    chk({nm, "_start"}, 32'(md_start), 32'd0);
    chk({nm, "_md"}, 32'(md_op) | md_a | md_b, 32'd0);
    chk({nm, "_cdb"}, 32'(cdb_req) | 32'(cdb_tag_out) | cdb_data_out, 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    reset = 1'b1; in_rst = 1'b1;
    issueque_ready = 1'b0; cdb_grant = 1'b0;
    #1;
    zero_outputs("reset_now");
    model_expect();
    @(negedge clk);
  endtask

  int first_req, starts, reqs, dones;

  initial begin
    reset = 1'b1; in_rst = 1'b1; m_active = 1'b0;
    issueque_ready = 1'b1; issueque_opcode = 3'd0; issueque_rs1_data = 32'd0;
    issueque_rs2_data = 32'd0; issueque_rd_tag = 6'd0; cdb_grant = 1'b0; md_result = 32'd0;
    #1;
    zero_outputs("reset_state");
    issueque_ready = 1'b0;
    repeat (2) @(posedge clk);
    idle(1'b1);
    idle(1'b0);

    // MUL tag 5 with grant held high.
    step(1'b1, 3'b000, 32'h11, 32'h22, 6'd5, 1'b1, MR);
    chk("mul_done", 32'(issueblk_done), 32'd1);
    idle(1'b1);
    chk("mul_start", 32'(md_start), 32'd1);
    chk("mul_busy", 32'(busy), 32'd1);
    chk("mul_md_a", md_a, 32'h11);
    idle(1'b1);
    idle(1'b1);
    chk("mul_start_gone", 32'(md_start), 32'd0);
    idle(1'b1);
    chk("mul_req", 32'(cdb_req), 32'd1);
    chk("mul_tag", 32'(cdb_tag_out), 32'd5);
    chk("mul_data", cdb_data_out, MR);
    idle(1'b1);
    chk("mul_busy_end", 32'(busy), 32'd0);

    // DIVU tag 9, grant withheld until offset 40.
    step(1'b1, 3'b101, 32'd100, 32'd7, 6'd9, 1'b0, MR);
    first_req = -1; reqs = 0; starts = 0;
    for (int k = 1; k <= 41; k++) begin
      idle(k == 40);
      if (md_start) starts += k;
      if (cdb_req) begin
        if (first_req < 0) first_req = k;
        reqs++;
        chk("divu_tag", 32'(cdb_tag_out), 32'd9);
        chk("divu_data", cdb_data_out, MR);
      end
    end
    chk("divu_start_at", 32'(starts), 32'd1);
    chk("divu_first_req", 32'(first_req), 32'd33);
    chk("divu_req_cycles", 32'(reqs), 32'd8);
    chk("divu_idle", 32'(busy), 32'd0);

    // REM by zero: bypass or full divide latency depending on build.
    step(1'b1, 3'b110, 32'h1234, 32'd0, 6'd3, 1'b1, MR);
    first_req = -1; starts = 0;
    for (int k = 1; k <= 40; k++) begin
      idle(1'b1);
      if (md_start) starts++;
      if (cdb_req && first_req < 0) begin
        first_req = k;
        chk("rem0_data", cdb_data_out, BYPASS_EN ? 32'h1234 : MR);
      end
    end
    chk("rem0_first_req", 32'(first_req), BYPASS_EN ? 32'd1 : 32'(DIV_LAT + 1));
    chk("rem0_starts", 32'(starts), BYPASS_EN ? 32'd0 : 32'd1);

    // Reset in the middle of a DIV discards it.
    step(1'b1, 3'b100, 32'd50, 32'd5, 6'd7, 1'b1, MR);
    repeat (4) idle(1'b1);
    do_reset();
    reqs = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1'b1);
      if (cdb_req) reqs++;
    end
    chk("rst_no_bcast", 32'(reqs), 32'd0);
    chk("idle_grant_busy", 32'(busy), 32'd0);
    step(1'b1, 3'b001, 32'd8, 32'd9, 6'd12, 1'b1, MR);
    chk("after_rst_accept", 32'(issueblk_done), 32'd1);
    repeat (5) idle(1'b1);

    // Ready held high with grant: one acceptance every MUL_LAT+2 cycles.
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, 6'($urandom), 1'b1, $urandom);
      if (issueblk_done) dones++;
    end
    chk("b2b_dones", 32'(dones), 32'd5);
    repeat (6) idle(1'b1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 1) == 1), 3'($urandom), $urandom,
             ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, 6'($urandom),
             ($urandom_range(0, 2) == 0), $urandom);
      end
    end
    repeat (DIV_LAT + 4) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
